// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch for a 160x120 RGB332 frame: generates linear read addresses, absorbs the read
// latency, and keeps colour aligned with delayed syncs. `VGA_PIXEL_FETCH_TEST_PATTERN_EN adds colour bars.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 1
) (
  input  logic              clock,
  input  logic              nreset,
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic              hblank,
  input  logic              hsync,
  input  logic              row_done,
  input  logic              vblank,
  input  logic              vsync,
  input  logic              frame_done,
  input  logic [7:0]        fb_rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_ren,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              line_err
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0]  ROW_END  = ROW_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [0:0] {SYNC_WAIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                err_q, err_d;

  logic                active, col_full, row_full, in_run, fetch, err_hit;
  logic [RD_LAT:0]     hs_q, vs_q;
  logic [RD_LAT-1:0]   vld_q;
  logic [7:0]          pix_src;
  logic [7:0]          pix_q;

  // Stage p0: decode of the counters and fetch qualification
  always_comb begin
    active   = ~hblank & ~vblank;
    col_full = (col_q == COL_END);
    row_full = (row_q == ROW_END);
    in_run   = (state_q == RUN);
    fetch    = in_run & active & ~col_full & ~row_full;
    err_hit  = in_run & ((active & (col_full | row_full)) |
                         (row_done & ~col_full & ~row_full));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q | err_hit;
    if (frame_done) begin
      // frame_done also overrides a coincident row_done, so the row restarts at 0
      state_d = RUN;
      addr_d  = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (in_run) begin
      if (fetch) begin
        col_d = col_q + COL_W'(1);
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
      end
      if (row_done) begin
        col_d = '0;
        if (!row_full) row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= SYNC_WAIT;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  assign fb_addr  = addr_q;
  assign line_err = err_q;

  // Stages p1..pRD_LAT: valid and syncs ride along with the outstanding read
  always_ff @(posedge clock) begin
    if (!nreset) begin
      hs_q  <= '1;
      vs_q  <= '1;
      vld_q <= '0;
    end else begin
      hs_q     <= {hs_q[RD_LAT-1:0], hsync};
      vs_q     <= {vs_q[RD_LAT-1:0], vsync};
      vld_q[0] <= fetch;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
  localparam int BAR_PX = H_ACTIVE / 8;

  function automatic logic [2:0] bar_index(input logic [COL_W-1:0] c);
    return 3'(c / COL_W'(BAR_PX));
  endfunction

  function automatic logic [7:0] bar_rgb(input logic [2:0] idx);
    return {idx, idx, idx[2:1]};
  endfunction

  logic [RD_LAT-1:0]      tm_q;
  logic [RD_LAT-1:0][2:0] bar_q;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      tm_q  <= '0;
      bar_q <= '0;
    end else begin
      tm_q[0]  <= test_mode;
      bar_q[0] <= bar_index(col_q);
      for (int i = 1; i < RD_LAT; i++) begin
        tm_q[i]  <= tm_q[i-1];
        bar_q[i] <= bar_q[i-1];
      end
    end
  end

  assign fb_ren  = fetch & ~test_mode;
  assign pix_src = tm_q[RD_LAT-1] ? bar_rgb(bar_q[RD_LAT-1]) : fb_rdata;
`else
  assign fb_ren  = fetch;
  assign pix_src = fb_rdata;
`endif

  // Stage pRD_LAT+1: output registers, colour blanked when no fetch is in flight
  always_ff @(posedge clock) begin
    if (!nreset) begin
      pix_q <= '0;
    end else begin
      pix_q <= vld_q[RD_LAT-1] ? pix_src : 8'h00;
    end
  end

  assign {red, green, blue} = pix_q;
  assign hsync_out          = hs_q[RD_LAT];
  assign vsync_out          = vs_q[RD_LAT];

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream consumer of the horizontal counter (hblank, hsync, row_done) and the vertical counter (vblank, vsync, frame_done) in the SoC VGA controller.
- Generates linear framebuffer read addresses for a 160x120 RGB332 frame.
- Absorbs the framebuffer read latency.
- Drives colour and delayed sync pins with colour and sync cycle-aligned.

Parameters:
H_ACTIVE, 160, active pixels per row
V_ACTIVE, 120, active rows per frame
ADDR_W, 15, framebuffer address width (must hold H_ACTIVE*V_ACTIVE-1 = 19199)
RD_LAT, 1, framebuffer read latency in clocks (legal 1..3)

Ports:
clock  in  1  system pixel clock
nreset  in  1  synchronous active-low reset
hblank  in  1  horizontal blank from horiz_cntr
hsync  in  1  active-low hsync from horiz_cntr
row_done  in  1  one-cycle end-of-row pulse from horiz_cntr
vblank  in  1  vertical blank from vertical counter
vsync  in  1  active-low vsync from vertical counter
frame_done  in  1  one-cycle end-of-frame pulse; coincides with the last row_done of the frame
fb_rdata  in  8  framebuffer read data, RGB332 {r[2:0],g[2:0],b[1:0]}
fb_addr  out  ADDR_W  framebuffer read address (registered)
fb_ren  out  1  framebuffer read enable
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
hsync_out  out  1  hsync delayed RD_LAT+1 clocks
vsync_out  out  1  vsync delayed RD_LAT+1 clocks
line_err  out  1  sticky timing error flag

Behaviour:
- Reset: nreset is synchronous, active-low; clock is clock. While nreset=0 the following hold:
  - fb_addr=0, fb_ren=0, red/green/blue=0.
  - hsync_out=1, vsync_out=1, line_err=0.
  - All delay-pipe stages cleared, with sync stages cleared to 1.
  - col=0, row=0, state=SYNC_WAIT.
- Reset mid-frame behaves identically; fetching resumes only after the next frame_done.
- active = ~hblank & ~vblank.
- State SYNC_WAIT:
  - fb_ren=0 and colour outputs held at 0.
  - Sync pipes still run.
  - On frame_done go to RUN, with fb_addr=0, col=0, row=0.
- State RUN:
  - fb_ren = active (combinational from inputs and state).
  - On each active cycle, fb_addr and col increment.
  - On row_done, col clears and row increments.
  - On frame_done, fb_addr, col and row all clear.
- Simultaneous row_done and frame_done: frame_done wins; row ends at 0, not 1.
- Error checks; any of these sets line_err, which stays set until reset:
  - An active cycle with col==H_ACTIVE. The fetch is suppressed (fb_ren=0) and fb_addr does not advance.
  - row_done with col!=H_ACTIVE while row<V_ACTIVE, i.e. a short line.
  - An active cycle with row==V_ACTIVE. The fetch is suppressed and fb_addr saturates.
- Address arithmetic:
  - fb_addr is unsigned ADDR_W bits and never wraps within a frame.
  - It returns to 0 only on frame_done.
- Latency:
  - Input sample at cycle N produces fb_addr/fb_ren at cycle N.
  - fb_rdata is valid at N+RD_LAT.
  - Output registers update at N+RD_LAT+1.
  - hsync, vsync and a valid flag (fb_ren) travel through identical RD_LAT+1-deep shift registers.
- Output colour: when the delayed valid flag is 1, {red,green,blue} = fb_rdata; otherwise it is 0.

Optional Feature:
- Macro VGA_PIXEL_FETCH_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, output colour is eight vertical bars: bar index = col/20 (0..7) drives {r,g,b} = {idx,idx,idx[2:1]}.
  - The col used for the bars is delayed through the same pipe as fb_rdata.
  - fb_ren is forced to 0; all latency and sync alignment are unchanged.
- Undefined: no test_mode port; colour is always sourced from fb_rdata.

Test Plan:
- Hold nreset=0 for 3 clocks mid-line:
  - Outputs equal their reset values.
  - After release, fb_ren stays 0 until the first frame_done.
- One full frame with RD_LAT=1 (horiz_cntr timing, 160 active per row, 120 rows):
  - fb_addr sweeps 0..19199 with no gaps.
  - 19200 fb_ren pulses.
  - line_err=0.
- Memory model returning data=addr[7:0] with RD_LAT=2:
  - The first pixel 0x00 appears 3 clocks after the first active input.
  - hsync_out falls exactly 3 clocks after hsync.
- Inject 161 active cycles in row 5: line_err=1, and fb_addr halts at 5*160+160=960 until row_done.
- Assert row_done and frame_done in the same cycle at row 60: the next active fetch uses fb_addr=0 and row=0.
- With VGA_PIXEL_FETCH_TEST_PATTERN_EN and test_mode=1:
  - col 0..19 gives output 0x00.
  - col 140..159 gives {7,7,3}=0xFF.
  - fb_ren=0 throughout.
